seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with frame-synchronous shadow update.
// Captured data waits in a pending register until the frame boundary, so a frame is never torn.
module seg_scan_driver #(
  parameter int NDIG = 4,
  parameter int DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   din,
  input  logic [NDIG-1:0]     dp_in,
  input  logic [NDIG-1:0]     dig_en,
  input  logic                lzb,
  output logic [7:0]          seg,
  output logic [NDIG-1:0]     an,
  output logic                pend,
  output logic                frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_index;
  logic [4*NDIG-1:0]  r_pend_val;
  logic [NDIG-1:0]    r_pend_dp;
  logic [NDIG-1:0]    r_pend_en;
  logic               r_pend_v;
  logic [4*NDIG-1:0]  r_sh_val;
  logic [NDIG-1:0]    r_sh_dp;
  logic [NDIG-1:0]    r_sh_en;
  logic               r_wrapped;
  logic [7:0]         r_seg;
  logic [NDIG-1:0]    r_an;
  logic               r_fd;

  logic               w_cnt_last;
  logic               w_idx_last;
  logic               w_boundary;
  logic               w_frame_start;
  logic [3:0]         w_nib;
  logic               w_dp;
  logic               w_den;
  logic               w_hi_zero;
  logic               w_acc;
  logic [NDIG-1:0]    w_zf;
  logic               w_blank_z;
  logic [7:0]         w_seg_next;
  logic [NDIG-1:0]    w_onehot;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_cnt_last    = (r_cnt == CW'(DIV - 1));
  assign w_idx_last    = (r_index == IW'(NDIG - 1));
  assign w_boundary    = en & w_cnt_last & w_idx_last;
  assign w_frame_start = (r_index == '0) && (r_cnt == '0);

  always_comb begin
    w_nib     = '0;
    w_dp      = 1'b0;
    w_den     = 1'b0;
    w_hi_zero = 1'b0;
    w_acc     = 1'b1;
    w_zf      = '0;
    // w_zf[k]: nibble k and every nibble above it are zero
    for (int unsigned j = 0; j < NDIG; j++) begin
      w_acc = w_acc & (r_sh_val[4*(NDIG-1-j) +: 4] == 4'h0);
      w_zf[NDIG-1-j] = w_acc;
    end
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (r_index == IW'(k)) begin
        w_nib     = r_sh_val[4*k +: 4];
        w_dp      = r_sh_dp[k];
        w_den     = r_sh_en[k];
        w_hi_zero = w_zf[k];
      end
    end
    w_blank_z  = lzb && (r_index != '0) && w_hi_zero;
    w_seg_next = w_den ? {w_dp, (w_blank_z ? 7'h00 : hex7(w_nib))} : 8'h00;
    w_onehot   = {{(NDIG-1){1'b0}}, 1'b1} << r_index;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_index   <= '0;
      r_wrapped <= 1'b0;
      r_seg     <= '0;
      r_an      <= '0;
      r_fd      <= 1'b0;
    end else if (en) begin
      r_seg <= w_seg_next;
      r_an  <= w_onehot;
      r_fd  <= w_frame_start & r_wrapped;
      if (w_cnt_last) begin
        r_cnt   <= '0;
        r_index <= w_idx_last ? '0 : r_index + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_boundary) r_wrapped <= 1'b1;
    end else begin
      r_seg <= '0;
      r_an  <= '0;
      r_fd  <= 1'b0;
    end
  end

  // Shadow value resets to zero with all digits enabled so a fresh display reads "0000".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_en  <= '0;
      r_pend_v   <= 1'b0;
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_sh_en    <= '1;
    end else if (w_boundary) begin
      if (load) begin
        r_sh_val <= din;
        r_sh_dp  <= dp_in;
        r_sh_en  <= dig_en;
      end else if (r_pend_v) begin
        r_sh_val <= r_pend_val;
        r_sh_dp  <= r_pend_dp;
        r_sh_en  <= r_pend_en;
      end
      r_pend_v <= 1'b0;
    end else if (load) begin
      r_pend_val <= din;
      r_pend_dp  <= dp_in;
      r_pend_en  <= dig_en;
      r_pend_v   <= 1'b1;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;
  assign pend       = r_pend_v;

endmodule
